regfile_sb: RTL and testbench

- Parametrised successor to the single-issue 32x32 register file: configurable XLEN and register count (RV32I/RV32E), optional write-to-read bypass, and a pending-write scoreboard.
- Sits between decode and execute.
- Decode issues destination tags and reads operands. Writeback clears tags and writes data.
- Stall output tells the control FSM when an operand is not yet valid.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 60 ++++++
 rtl/regfile_sb.sv | 112 +++++++++++
 tb/tb_regfile_sb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file with scoreboard.
//   XLEN_DEF   : default data width
//   NREG_RV32I : register count for the full integer base set
//   NREG_RV32E : register count for the embedded base set
//   AW_MAX     : widest register address supported (32 registers)
//   fwd_sel()  : true when a same-cycle writeback targets a read address
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREG_RV32I = 32;
  localparam int NREG_RV32E = 16;
  localparam int AW_MAX     = 5;

  // Bypass hit: a live write to the register being read. x0 never forwards
  // because writes to it are discarded.
  function automatic logic fwd_sel(input logic              wr_en,
                                   input logic [AW_MAX-1:0] wr_addr,
                                   input logic [AW_MAX-1:0] rd_addr);
    return wr_en && (wr_addr == rd_addr) && (rd_addr != '0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en_i, wr_addr_i  : writeback clears the destination's busy bit
//   iss_en_i, iss_addr_i: issue marks the destination busy (wins a collision)
//   rsN_addr_i          : operand addresses looked up combinationally
//   rsN_mask_i          : suppress the busy indication (same-cycle forward)
//   rsN_busy_o          : operand pending, based on current (pre-update) state
//   busy_vec_o          : registered busy bits, bit 0 always 0
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_RV32I,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic            iss_en_i,
  input  logic [AW-1:0]   iss_addr_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  input  logic            rs1_mask_i,
  input  logic            rs2_mask_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  output logic [NREG-1:0] busy_vec_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // x0 has no producer to wait for.
  assign busy_d[0] = 1'b0;

  // Set is ORed in after the clear so a new producer supersedes a
  // completing one targeting the same register.
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      assign set_hit    = iss_en_i && (iss_addr_i == AW'(gi));
      assign clr_hit    = wr_en_i  && (wr_addr_i  == AW'(gi));
      assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o = busy_q[rs1_addr_i] & ~rs1_mask_i;
  assign rs2_busy_o = busy_q[rs2_addr_i] & ~rs2_mask_i;
  assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read / one-write register file with optional write-to-read forwarding
// and a pending-write scoreboard, placed between decode and execute.
//   clk, rst              : clock, asynchronous active-high reset
//   rd_en, rs1/rs2_addr   : capture operands this cycle (blocked by stall)
//   rs1_data, rs2_data    : registered operands, held when not captured
//   wr_en/addr/data       : writeback port; x0 writes are dropped
//   wb_update             : registered copy of wr_en
//   iss_en, iss_addr      : mark a destination as pending
//   rs1_busy, rs2_busy    : operand pending (combinational)
//   stall                 : rd_en while either operand is pending
//   busy_vec              : registered scoreboard state
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREG   = NREG_RV32I,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic            wb_update,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            stall,
  output logic [NREG-1:0] busy_vec
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic            wb_q;
  logic            hit1, hit2;

  // Forward hits only exist when bypassing is enabled; with it disabled the
  // read sees the old contents and the busy bit stays visible until the
  // scoreboard clears it at the edge.
  assign hit1 = (BYPASS != 0) &&
                fwd_sel(wr_en, AW_MAX'(wr_addr), AW_MAX'(rs1_addr));
  assign hit2 = (BYPASS != 0) &&
                fwd_sel(wr_en, AW_MAX'(wr_addr), AW_MAX'(rs2_addr));

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_mask_i (hit1),
    .rs2_mask_i (hit2),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .busy_vec_o (busy_vec)
  );

  assign stall = rd_en & (rs1_busy | rs2_busy);

  // Register array. The whole array clears on reset, so it is built from
  // flops rather than block RAM. mem_q[0] is never written and stays zero,
  // which makes x0 read as zero without an explicit address check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (rd_en && !stall) begin
      rs1_d = hit1 ? wr_data : mem_q[rs1_addr];
      rs2_d = hit2 ? wr_data : mem_q[rs2_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_q <= '0;
      rs2_q <= '0;
      wb_q  <= 1'b0;
    end else begin
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      wb_q  <= wr_en;
    end
  end

  assign rs1_data  = rs1_q;
  assign rs2_data  = rs2_q;
  assign wb_update = wb_q;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  typedef struct {
    logic        rd_en;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [31:0] e_rs1;     // bypassing instance
    logic [31:0] e_rs2;
    logic        e_wb;
    logic        e_stall;
    logic [31:0] n_rs1;     // read-before-write instance
    logic [31:0] n_rs2;
    logic        n_stall;
    logic [31:0] e_busy;    // identical for both instances
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rd_en, wr_en, iss_en;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_addr;
  logic [31:0] wr_data;

  logic [31:0] a_rs1, a_rs2, n_rs1, n_rs2, s_rs1, s_rs2;
  logic        a_wb, n_wb, s_wb;
  logic        a_b1, a_b2, n_b1, n_b2, s_b1, s_b2;
  logic        a_stall, n_stall, s_stall;
  logic [31:0] a_busy, n_busy;
  logic [15:0] s_busy;

  int total = 0;
  int bad   = 0;

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(a_rs1), .rs2_data(a_rs2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wb_update(a_wb), .iss_en(iss_en), .iss_addr(iss_addr),
    .rs1_busy(a_b1), .rs2_busy(a_b2), .stall(a_stall), .busy_vec(a_busy));

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1), .rs2_data(n_rs2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wb_update(n_wb), .iss_en(iss_en), .iss_addr(iss_addr),
    .rs1_busy(n_b1), .rs2_busy(n_b2), .stall(n_stall), .busy_vec(n_busy));

  regfile_sb #(.XLEN(32), .NREG(16), .BYPASS(1)) dut16 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rs1_addr(rs1_addr[3:0]),
    .rs2_addr(rs2_addr[3:0]), .rs1_data(s_rs1), .rs2_data(s_rs2), .wr_en(wr_en),
    .wr_addr(wr_addr[3:0]), .wr_data(wr_data), .wb_update(s_wb), .iss_en(iss_en),
    .iss_addr(iss_addr[3:0]), .rs1_busy(s_b1), .rs2_busy(s_b2), .stall(s_stall),
    .busy_vec(s_busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic drive(input logic re, input logic [4:0] r1, input logic [4:0] r2,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia);
    rd_en = re; rs1_addr = r1; rs2_addr = r2;
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  function automatic vec_t mk(input logic re, input logic [4:0] r1, input logic [4:0] r2,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ie, input logic [4:0] ia,
                              input logic [31:0] er1, input logic [31:0] er2,
                              input logic ewb, input logic est,
                              input logic [31:0] nr1, input logic [31:0] nr2,
                              input logic nst, input logic [31:0] eb);
    vec_t v;
    v.rd_en = re; v.rs1 = r1; v.rs2 = r2; v.we = we; v.wa = wa; v.wd = wd;
    v.ie = ie; v.ia = ia; v.e_rs1 = er1; v.e_rs2 = er2; v.e_wb = ewb;
    v.e_stall = est; v.n_rs1 = nr1; v.n_rs2 = nr2; v.n_stall = nst; v.e_busy = eb;
    return v;
  endfunction

  localparam logic [31:0] V7 = 32'h1234_5678;
  localparam logic [31:0] VA = 32'hA5A5_A5A5;

  vec_t tbl [13];

  initial begin
    //            rd rs1 rs2 we wa  wd            ie ia   e_rs1 e_rs2 wb st  n_rs1 n_rs2 nst busy
    tbl[0]  = mk(0, 0, 0, 1, 7,  V7,           0, 0,  0,    0,    1, 0,  0,    0,    0,  32'h0);
    tbl[1]  = mk(1, 7, 0, 0, 0,  0,            0, 0,  V7,   0,    0, 0,  V7,   0,    0,  32'h0);
    tbl[2]  = mk(1, 0, 7, 1, 0,  32'hFFFFFFFF, 0, 0,  0,    V7,   1, 0,  0,    V7,   0,  32'h0);
    tbl[3]  = mk(1, 7, 3, 1, 3,  VA,           0, 0,  V7,   VA,   1, 0,  V7,   0,    0,  32'h0);
    tbl[4]  = mk(1, 3, 3, 0, 0,  0,            0, 0,  VA,   VA,   0, 0,  VA,   VA,   0,  32'h0);
    tbl[5]  = mk(0, 0, 0, 0, 0,  0,            1, 9,  VA,   VA,   0, 0,  VA,   VA,   0,  32'h200);
    tbl[6]  = mk(1, 9, 7, 0, 0,  0,            0, 0,  VA,   VA,   0, 1,  VA,   VA,   1,  32'h200);
    tbl[7]  = mk(1, 9, 7, 1, 9,  32'h55,       0, 0,  32'h55, V7, 1, 0,  VA,   VA,   1,  32'h0);
    tbl[8]  = mk(1, 9, 7, 0, 0,  0,            0, 0,  32'h55, V7, 0, 0,  32'h55, V7, 0,  32'h0);
    tbl[9]  = mk(0, 0, 0, 1, 4,  32'h44,       1, 4,  32'h55, V7, 1, 0,  32'h55, V7, 0,  32'h10);
    tbl[10] = mk(1, 4, 0, 0, 0,  0,            0, 0,  32'h55, V7, 0, 1,  32'h55, V7, 1,  32'h10);
    tbl[11] = mk(1, 0, 0, 0, 0,  0,            1, 0,  0,    0,    0, 0,  0,    0,    0,  32'h10);
    tbl[12] = mk(0, 0, 0, 1, 4,  32'h99,       1, 6,  0,    0,    1, 0,  0,    0,    0,  32'h40);

    // Power-on reset
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset rs1_data", a_rs1, 32'h0);
    chk("reset wb_update", {31'b0, a_wb}, 32'h0);
    chk("reset busy_vec", a_busy, 32'h0);
    chk("reset stall", {31'b0, a_stall}, 32'h0);

    // Table: drive, check combinational stall, clock, check registered outputs
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rd_en, tbl[i].rs1, tbl[i].rs2, tbl[i].we, tbl[i].wa, tbl[i].wd,
            tbl[i].ie, tbl[i].ia);
      #1;
      chk($sformatf("v%0d stall", i), {31'b0, a_stall}, {31'b0, tbl[i].e_stall});
      chk($sformatf("v%0d stall_nb", i), {31'b0, n_stall}, {31'b0, tbl[i].n_stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rs1", i), a_rs1, tbl[i].e_rs1);
      chk($sformatf("v%0d rs2", i), a_rs2, tbl[i].e_rs2);
      chk($sformatf("v%0d wb", i), {31'b0, a_wb}, {31'b0, tbl[i].e_wb});
      chk($sformatf("v%0d busy", i), a_busy, tbl[i].e_busy);
      chk($sformatf("v%0d rs1_nb", i), n_rs1, tbl[i].n_rs1);
      chk($sformatf("v%0d rs2_nb", i), n_rs2, tbl[i].n_rs2);
      chk($sformatf("v%0d busy_nb", i), n_busy, tbl[i].e_busy);
      @(negedge clk);
    end

    // Mid-operation asynchronous reset during a write of x5
    drive(1'b1, 5'd7, 5'd0, 1'b1, 5'd10, 32'h1, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    chk("pre-rst rs1", a_rs1, V7);
    chk("pre-rst wb", {31'b0, a_wb}, 32'h1);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd8);
    #2 rst = 1'b1;
    #1;
    chk("async rst rs1", a_rs1, 32'h0);
    chk("async rst wb", {31'b0, a_wb}, 32'h0);
    chk("async rst busy", a_busy, 32'h0);
    chk("async rst busy_nb", n_busy, 32'h0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;
    drive(1'b1, 5'd5, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    chk("post-rst x5", a_rs1, 32'h0);
    chk("post-rst x7", a_rs2, 32'h0);
    chk("post-rst wb", {31'b0, a_wb}, 32'h0);
    chk("post-rst busy", a_busy, 32'h0);

    // 16-register instance
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd15, 32'h1, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    chk("e wb", {31'b0, s_wb}, 32'h1);
    @(negedge clk);
    drive(1'b1, 5'd15, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    chk("e stall", {31'b0, s_stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("e x15", s_rs1, 32'h1);
    chk("e x0", s_rs2, 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd15);
    @(posedge clk);
    #1;
    chk("e busy x15", {16'h0, s_busy}, 32'h0000_8000);
    @(negedge clk);
    drive(1'b1, 5'd15, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    chk("e stall x15", {31'b0, s_stall}, 32'h1);
    chk("e rs1_busy", {31'b0, s_b1}, 32'h1);
    @(negedge clk);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
